// File: rtl/fetch_pc_gen_pkg.sv
// rtl/fetch_pc_gen_pkg.sv - shared types, constants and counter helpers for the fetch PC stage
//
// Contents:
//   fetch_state_t  BOOT / RUN / HALT sequencing of the fetch PC
//   EXC_*          bit positions of the core's registered exception vector
//   HALT_MASK_DEF  default set of exception bits that freeze fetch
//   RESET_VEC      fetch PC after reset
//   btb_entry_t    BTB entry layout for the default 64-bit / 16-entry build
//   ctr_inc/dec    saturating 2-bit direction counter helpers
package fetch_pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Exception vector order as produced by the core.
    localparam int EXC_FETCH_ERROR  = 0;
    localparam int EXC_DECODE_ERROR = 1;
    localparam int EXC_MEM_ACCESS   = 2;
    localparam int EXC_ECALL        = 3;
    localparam int EXC_EBREAK       = 4;

    localparam logic [7:0] HALT_MASK_DEF = (8'd1 << EXC_FETCH_ERROR)
                                         | (8'd1 << EXC_DECODE_ERROR)
                                         | (8'd1 << EXC_MEM_ACCESS)
                                         | (8'd1 << EXC_ECALL)
                                         | (8'd1 << EXC_EBREAK);

    localparam logic [63:0] RESET_VEC = 64'h0000_0000_8000_0000;

    localparam int XLEN          = 64;
    localparam int BTB_IDX_W_DEF = 4;
    localparam int BTB_TAG_W_DEF = XLEN - BTB_IDX_W_DEF - 2;

    typedef logic [1:0] btb_ctr_t;

    // Fresh allocations start weakly taken so one not-taken outcome flips them.
    localparam btb_ctr_t CTR_WEAK_TAKEN = 2'b10;

    typedef struct packed {
        logic                     valid;
        logic [BTB_TAG_W_DEF-1:0] tag;
        logic [XLEN-1:0]          target;
        btb_ctr_t                 ctr;
    } btb_entry_t;

    function automatic btb_ctr_t ctr_inc(input btb_ctr_t c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic btb_ctr_t ctr_dec(input btb_ctr_t c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// rtl/fetch_pc_gen_if.sv - core-facing bundle of the fetch PC generator
//
// Signals (direction seen from fetch_pc_gen, the slave side):
//   stall_i, redirect_i, redirect_pc_i          PC control from the core
//   upd_valid_i, upd_pc_i, upd_target_i,
//   upd_taken_i                                 resolved control flow for the BTB
//   exception_i                                 registered exception vector
//   cnt_preload_i, cnt_preload_val_i            test hook: load the redirect counter
//   pc_o, pred_taken_o, pred_target_o           fetch PC and its prediction
//   halted_o, redirect_cnt_o                    status
interface fetch_pc_gen_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  stall_i;
    logic                  redirect_i;
    logic [DATA_WIDTH-1:0] redirect_pc_i;
    logic                  upd_valid_i;
    logic [DATA_WIDTH-1:0] upd_pc_i;
    logic [DATA_WIDTH-1:0] upd_target_i;
    logic                  upd_taken_i;
    logic [7:0]            exception_i;
    logic                  cnt_preload_i;
    logic [31:0]           cnt_preload_val_i;

    logic [DATA_WIDTH-1:0] pc_o;
    logic                  pred_taken_o;
    logic [DATA_WIDTH-1:0] pred_target_o;
    logic                  halted_o;
    logic [31:0]           redirect_cnt_o;

    modport master (
        output stall_i, redirect_i, redirect_pc_i,
        output upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
        output exception_i, cnt_preload_i, cnt_preload_val_i,
        input  pc_o, pred_taken_o, pred_target_o, halted_o, redirect_cnt_o
    );

    modport slave (
        input  stall_i, redirect_i, redirect_pc_i,
        input  upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
        input  exception_i, cnt_preload_i, cnt_preload_val_i,
        output pc_o, pred_taken_o, pred_target_o, halted_o, redirect_cnt_o
    );

endinterface

// File: rtl/fetch_pc_gen_btb.sv
// rtl/fetch_pc_gen_btb.sv - direct-mapped branch target buffer with 2-bit counters
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (clears every entry)
//   lookup_pc_i         PC to predict (combinational lookup)
//   lookup_taken_o      hit and counter in a taken state
//   lookup_target_o     stored target on hit, zero on miss
//   upd_en_i            apply a resolved control-flow outcome this cycle
//   upd_pc_i            PC of the resolved instruction
//   upd_target_i        resolved taken target
//   upd_taken_i         resolved direction
module fetch_pc_gen_btb
    import fetch_pc_gen_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int BTB_ENTRIES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] lookup_pc_i,
    output logic                  lookup_taken_o,
    output logic [DATA_WIDTH-1:0] lookup_target_o,
    input  logic                  upd_en_i,
    input  logic [DATA_WIDTH-1:0] upd_pc_i,
    input  logic [DATA_WIDTH-1:0] upd_target_i,
    input  logic                  upd_taken_i
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

    // Same layout as btb_entry_t, sized from this instance's parameters.
    typedef struct packed {
        logic                  valid;
        logic [TAG_W-1:0]      tag;
        logic [DATA_WIDTH-1:0] target;
        btb_ctr_t              ctr;
    } entry_t;

    entry_t mem_q [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    entry_t           lk_entry;
    entry_t           up_entry;
    logic             lk_hit;
    logic             up_hit;

    // Instructions are word aligned; the low PC bits never select anything.
    logic unused_low_bits;
    assign unused_low_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

    assign lk_idx = lookup_pc_i[IDX_W+1:2];
    assign lk_tag = lookup_pc_i[DATA_WIDTH-1:IDX_W+2];
    assign up_idx = upd_pc_i[IDX_W+1:2];
    assign up_tag = upd_pc_i[DATA_WIDTH-1:IDX_W+2];

    // Lookup reads the registered array, so a same-cycle update to the same
    // index is only seen from the next cycle on (read-before-write).
    assign lk_entry = mem_q[lk_idx];
    assign up_entry = mem_q[up_idx];
    assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);
    assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

    assign lookup_taken_o  = lk_hit && lk_entry.ctr[1];
    assign lookup_target_o = lk_hit ? lk_entry.target : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (upd_en_i) begin
            if (up_hit) begin
                if (upd_taken_i) begin
                    mem_q[up_idx].ctr    <= ctr_inc(up_entry.ctr);
                    mem_q[up_idx].target <= {upd_target_i[DATA_WIDTH-1:2], 2'b00};
                end else begin
                    mem_q[up_idx].ctr    <= ctr_dec(up_entry.ctr);
                end
            end else if (upd_taken_i) begin
                // Miss on a taken outcome: replace whatever aliases to this slot.
                mem_q[up_idx].valid  <= 1'b1;
                mem_q[up_idx].tag    <= up_tag;
                mem_q[up_idx].target <= {upd_target_i[DATA_WIDTH-1:2], 2'b00};
                mem_q[up_idx].ctr    <= CTR_WEAK_TAKEN;
            end
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch program-counter generator with BTB-driven next-PC selection
//
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset
//   bus     fetch_pc_gen_if.slave: stall/redirect/BTB update/exception inputs,
//           fetch PC, prediction, halted flag and redirect counter outputs
//
// Next PC priority in RUN: halt request, redirect, stall, BTB prediction, PC+4.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter int          DATA_WIDTH  = 64,
    parameter logic [63:0] RESET_VEC   = fetch_pc_gen_pkg::RESET_VEC,
    parameter int          BTB_ENTRIES = 16,
    parameter logic [7:0]  HALT_MASK   = HALT_MASK_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_pc_gen_if.slave bus
);

    localparam logic [DATA_WIDTH-1:0] PC_RESET = RESET_VEC[DATA_WIDTH-1:0];
    localparam logic [31:0]           CNT_MAX  = 32'hFFFF_FFFF;

    fetch_state_t          state_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  halted_q;
    logic [31:0]           redirect_cnt_q;

    logic                  pred_taken;
    logic [DATA_WIDTH-1:0] pred_target;
    logic                  halt_req;
    logic                  btb_upd_en;

    assign halt_req   = |(bus.exception_i & HALT_MASK);
    // Training is independent of PC selection but only meaningful while running.
    assign btb_upd_en = bus.upd_valid_i && (state_q == RUN);

    fetch_pc_gen_btb #(
        .DATA_WIDTH  (DATA_WIDTH),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .lookup_pc_i     (pc_q),
        .lookup_taken_o  (pred_taken),
        .lookup_target_o (pred_target),
        .upd_en_i        (btb_upd_en),
        .upd_pc_i        (bus.upd_pc_i),
        .upd_target_i    (bus.upd_target_i),
        .upd_taken_i     (bus.upd_taken_i)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= BOOT;
            pc_q           <= PC_RESET;
            halted_q       <= 1'b0;
            redirect_cnt_q <= '0;
        end else begin
            case (state_q)
                // One cycle to let the instruction RAM's synchronous read of
                // RESET_VEC complete before the PC starts moving.
                BOOT: begin
                    state_q <= RUN;
                end
                RUN: begin
                    if (halt_req) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end else if (bus.redirect_i) begin
                        pc_q <= {bus.redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
                        if (redirect_cnt_q != CNT_MAX) begin
                            redirect_cnt_q <= redirect_cnt_q + 32'd1;
                        end
                    end else if (bus.stall_i) begin
                        pc_q <= pc_q;
                    end else if (pred_taken) begin
                        pc_q <= pred_target;
                    end else begin
                        pc_q <= pc_q + DATA_WIDTH'(4);
                    end
                end
                HALT: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase

            // Preload lets long saturation runs be exercised without 2^32 redirects.
            if (bus.cnt_preload_i) begin
                redirect_cnt_q <= bus.cnt_preload_val_i;
            end
        end
    end

    assign bus.pc_o           = pc_q;
    assign bus.pred_taken_o   = pred_taken;
    assign bus.pred_target_o  = pred_target;
    assign bus.halted_o       = halted_q;
    assign bus.redirect_cnt_o = redirect_cnt_q;

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Program-counter generation stage that sits directly upstream of the pipelined core and drives its fetch PC input every cycle.
- Holds the architectural fetch PC and selects the next PC by priority: halt, redirect, stall, prediction, sequential.
- Contains a direct-mapped branch target buffer (BTB) with 2-bit counters, so fetch can follow taken branches/jumps instead of always predicting PC+4.
- Freezes fetch permanently (until reset) when the core reports an exception.

Parameters:
DATA_WIDTH, 64, PC / target width
RESET_VEC, 64'h0000_0000_8000_0000, PC value after reset
BTB_ENTRIES, 16, BTB depth (power of two, >=2)
HALT_MASK, 8'b0001_1111, exception bits that force HALT

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
stall_i  in  1  load-use stall from core; hold PC
redirect_i  in  1  misprediction flush from EX
redirect_pc_i  in  DATA_WIDTH  correct next PC from EX
upd_valid_i  in  1  resolved control-flow instruction in EX
upd_pc_i  in  DATA_WIDTH  PC of the resolved instruction
upd_target_i  in  DATA_WIDTH  resolved taken target
upd_taken_i  in  1  resolved direction
exception_i  in  8  registered exception vector from core
pc_o  out  DATA_WIDTH  current fetch PC
pred_taken_o  out  1  BTB predicts pc_o is taken
pred_target_o  out  DATA_WIDTH  predicted target (valid when pred_taken_o)
halted_o  out  1  fetch frozen by exception
redirect_cnt_o  out  32  saturating count of accepted redirects

Behaviour:
- Clock and reset: single clock clk_i; all state updates on posedge clk_i. rst_i is synchronous and active-high.
- Reset values:
  - pc_o = RESET_VEC
  - state = BOOT
  - all BTB valid bits = 0, so pred_taken_o = 0 and pred_target_o = 0
  - halted_o = 0
  - redirect_cnt_o = 0
- State machine (BOOT, RUN, HALT):
  - BOOT: lasts exactly 1 cycle. pc_o holds RESET_VEC to cover the instruction RAM's synchronous read. Next state is RUN. All inputs except rst_i are ignored.
  - RUN: next PC selected by priority:
    1. (exception_i & HALT_MASK) != 0 -> state HALT, pc_o holds.
    2. redirect_i -> pc_o <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00}; redirect_cnt_o increments, saturating at 32'hFFFF_FFFF.
    3. stall_i -> pc_o holds.
    4. pred_taken_o -> pc_o <= pred_target_o.
    5. otherwise pc_o <= pc_o + 4, wrapping modulo 2^DATA_WIDTH.
  - HALT: pc_o frozen, halted_o = 1. Redirects and stalls are ignored. Only rst_i exits HALT.
- Latency: a redirect in cycle N is visible on pc_o in cycle N+1. The BTB lookup is combinational on pc_o (zero-cycle prediction).
- BTB organisation:
  - index = pc[IDX+1:2], where IDX = log2(BTB_ENTRIES)
  - tag = pc[DATA_WIDTH-1:IDX+2]
  - each entry stores: valid, tag, target, 2-bit counter
  - hit = valid && tag match
  - pred_taken_o = hit && ctr[1]
  - pred_target_o = entry target on hit, else 0
- BTB update, when upd_valid_i is high (applied in RUN only, ignored in BOOT and HALT):
  - hit and taken: ctr saturating increment (max 2'b11); target <= upd_target_i.
  - hit and not taken: ctr saturating decrement (min 2'b00); entry stays valid.
  - miss and taken: allocate/overwrite the entry: valid = 1, new tag, target = upd_target_i, ctr = 2'b10.
  - miss and not taken: no change.
- Lookup and update to the same index in the same cycle: the lookup sees pre-update contents (read-before-write).
- upd_valid_i and redirect_i in the same cycle: both take effect; the update is independent of PC selection.
- Targets are stored with bits [1:0] forced to 00.

Decomposition:
- pipeline_pkg gains:
  - typedef fetch_state_t {BOOT, RUN, HALT}
  - struct btb_entry_t {valid, tag, target, ctr}
  - localparam RESET_VEC
  - HALT_MASK bit positions matching the existing exception order (FetchError, DecodeError, MemAccessError, ECALL, EBREAK)
- One sub-module: btb
  - combinational lookup port
  - synchronous update port
  - synchronous clear on reset
- fetch_pc_gen keeps the FSM, the next-PC mux and redirect_cnt_o.

Test Plan:
- Reset then run 4 cycles with no stimulus -> pc_o = 8000_0000, 8000_0000 (BOOT), 8000_0004, 8000_0008; pred_taken_o = 0 throughout.
- stall_i and redirect_i both high in RUN, redirect_pc_i = 8000_0103 -> next pc_o = 8000_0100; redirect_cnt_o = 1. stall_i alone for 2 cycles -> pc_o held both cycles.
- upd_valid_i with upd_pc_i = 8000_0010, upd_target_i = 8000_0040, taken -> entry allocated with ctr = 10. When pc_o later reaches 8000_0010, pred_taken_o = 1 and the following pc_o = 8000_0040. Two not-taken updates on the same PC -> prediction falls through to 8000_0014.
- Aliasing: allocate at 8000_0010, then a taken update at 8000_0050 (same index for 16 entries, different tag) -> entry overwritten; lookup at 8000_0010 misses.
- exception_i = 8'b0000_1000 (ECALL) -> halted_o = 1 next cycle; pc_o constant over 10 cycles despite redirects. rst_i asserted mid-halt -> returns to BOOT with pc_o = RESET_VEC and BTB cleared.
- pc_o = FFFF_FFFF_FFFF_FFFC, no prediction -> next pc_o = 0 (wrap-around). Force 2^32 redirects via a preload hook -> redirect_cnt_o stays at FFFF_FFFF.
